// File: rtl/bus_demux_pkg.sv
// Shared constants, slot-state type and helpers for the 1-to-4 registered bus demux.
package bus_demux_pkg;

    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;
    localparam int CNT_W   = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    function automatic logic [NUM_OUT-1:0] sel_onehot(
        input logic [SEL_W-1:0] sel
    );
        logic [NUM_OUT-1:0] r;
        r      = '0;
        r[sel] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/bus_demux_if.sv
// Upstream handshake plus the four registered downstream channels.
interface bus_demux_if
    import bus_demux_pkg::*;
#(
    parameter int BUS_WIDTH = 8
);

    logic [BUS_WIDTH-1:0] in_data;
    logic [SEL_W-1:0]     in_sel;
    logic                 in_valid;
    logic                 in_ready;

    logic [BUS_WIDTH-1:0] y0;
    logic [BUS_WIDTH-1:0] y1;
    logic [BUS_WIDTH-1:0] y2;
    logic [BUS_WIDTH-1:0] y3;
    logic [NUM_OUT-1:0]   out_valid;
    logic [NUM_OUT-1:0]   out_ready;

    modport master (
        output in_data,
        output in_sel,
        output in_valid,
        input  in_ready,
        input  y0,
        input  y1,
        input  y2,
        input  y3,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_sel,
        input  in_valid,
        output in_ready,
        output y0,
        output y1,
        output y2,
        output y3,
        output out_valid,
        input  out_ready
    );

endinterface

// File: rtl/bus_demux_slot.sv
// One-entry register slot: holds a word until the downstream channel takes it.
module bus_demux_slot
    import bus_demux_pkg::*;
#(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr,
    input  logic [BUS_WIDTH-1:0] wdata,
    input  logic                 rd,
    output logic                 valid,
    output logic [BUS_WIDTH-1:0] data
);

    slot_state_e state;
    slot_state_e state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // wr into a FULL slot only arrives together with rd (upstream ready rule)
    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: begin
                if (wr) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (rd && !wr) begin
                    state_nxt = EMPTY;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    always_comb begin
        valid = (state == FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (wr) begin
            data <= wdata;
        end
    end

endmodule

// File: rtl/bus_demux_1to4_reg.sv
// 1-to-4 demux with a registered slot per channel.
// Define BUS_DEMUX_COUNT_EN to add per-channel 8-bit transfer counters cnt0..cnt3.
module bus_demux_1to4_reg
    import bus_demux_pkg::*;
#(
    parameter int BUS_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    bus_demux_if.slave       bus
`ifdef BUS_DEMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
`endif
);

    logic [NUM_OUT-1:0]   valid;
    logic [NUM_OUT-1:0]   wr;
    logic                 ready;
    logic [BUS_WIDTH-1:0] data [NUM_OUT];

    // ready depends only on the addressed slot, never on in_valid
    always_comb begin
        ready = ~valid[bus.in_sel] | bus.out_ready[bus.in_sel];
    end

    always_comb begin
        wr = '0;
        if (bus.in_valid && ready) begin
            wr = sel_onehot(bus.in_sel);
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
        bus_demux_slot #(
            .BUS_WIDTH (BUS_WIDTH)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .wr    (wr[g]),
            .wdata (bus.in_data),
            .rd    (bus.out_ready[g]),
            .valid (valid[g]),
            .data  (data[g])
        );
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid;
    assign bus.y0        = data[0];
    assign bus.y1        = data[1];
    assign bus.y2        = data[2];
    assign bus.y3        = data[3];

`ifdef BUS_DEMUX_COUNT_EN
    logic [CNT_W-1:0] cnt [NUM_OUT];

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt[g] <= '0;
            end else if (valid[g] && bus.out_ready[g]) begin
                cnt[g] <= cnt[g] + 1'b1;
            end
        end
    end

    assign cnt0 = cnt[0];
    assign cnt1 = cnt[1];
    assign cnt2 = cnt[2];
    assign cnt3 = cnt[3];
`endif

endmodule

// File: tb/tb_bus_demux_1to4_reg.sv
// Scoreboard bench for bus_demux_1to4_reg: directed vectors plus per-channel expect queues.
module tb_bus_demux_1to4_reg;
    import bus_demux_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_demux_if #(.BUS_WIDTH(8)) bus ();

`ifdef BUS_DEMUX_COUNT_EN
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [7:0] cnt2;
    logic [7:0] cnt3;
`endif

    bus_demux_1to4_reg #(
        .BUS_WIDTH (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus)
`ifdef BUS_DEMUX_COUNT_EN
        ,
        .cnt0 (cnt0),
        .cnt1 (cnt1),
        .cnt2 (cnt2),
        .cnt3 (cnt3)
`endif
    );

    int passed = 0;
    int total  = 0;
    bit mon_en = 1'b0;
    logic [7:0] q [4][$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] yof(input int n);
        case (n)
            0:       return bus.y0;
            1:       return bus.y1;
            2:       return bus.y2;
            default: return bus.y3;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares delivered words against queued expectations
    always @(negedge clk) begin
        logic [3:0] exp_v;
        logic       exp_rdy;
        if (mon_en) begin
            for (int n = 0; n < 4; n++) begin
                exp_v[n] = (q[n].size() != 0);
            end
            check("sb out_valid", {28'd0, bus.out_valid}, {28'd0, exp_v});
            exp_rdy = !exp_v[bus.in_sel] || bus.out_ready[bus.in_sel];
            check("sb in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
            if (rst) begin
                for (int n = 0; n < 4; n++) begin
                    q[n].delete();
                end
            end else begin
                for (int n = 0; n < 4; n++) begin
                    if (exp_v[n] && bus.out_ready[n]) begin
                        check($sformatf("sb y%0d", n), {24'd0, yof(n)},
                              {24'd0, q[n].pop_front()});
                    end
                end
                if (bus.in_valid && exp_rdy) begin
                    q[bus.in_sel].push_back(bus.in_data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = 8'h00;
        bus.out_ready = 4'b0000;
        tick();
        tick();
        rst    = 1'b0;
        mon_en = 1'b1;

        // reset state
        @(negedge clk);
        check("rst out_valid", {28'd0, bus.out_valid}, 32'h0);
        check("rst in_ready", {31'd0, bus.in_ready}, 32'h1);
        check("rst y0", {24'd0, bus.y0}, 32'h0);
        check("rst y3", {24'd0, bus.y3}, 32'h0);
        tick();

        // single word to channel 2, stalled
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd2;
        bus.in_data  = 8'hA5;
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("ch2 out_valid", {28'd0, bus.out_valid}, 32'h4);
        check("ch2 y2", {24'd0, bus.y2}, 32'hA5);
        tick();
        tick();
        tick();
        @(negedge clk);
        check("ch2 hold y2", {24'd0, bus.y2}, 32'hA5);
        check("ch2 hold valid", {28'd0, bus.out_valid}, 32'h4);
        tick();

        // channel 1 full and stalled blocks sel=1 but not sel=3
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd1;
        bus.in_data  = 8'h11;
        tick();
        bus.in_data = 8'h22;
        @(negedge clk);
        check("full ch1 ready", {31'd0, bus.in_ready}, 32'h0);
        tick();
        bus.in_sel  = 2'd3;
        bus.in_data = 8'h33;
        @(negedge clk);
        check("free ch3 ready", {31'd0, bus.in_ready}, 32'h1);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("ch3 out_valid", {28'd0, bus.out_valid}, 32'he);
        check("ch3 y3", {24'd0, bus.y3}, 32'h33);
        check("ch1 y1 kept", {24'd0, bus.y1}, 32'h11);
        tick();

        // drain everything
        bus.out_ready = 4'b1111;
        tick();
        @(negedge clk);
        check("drain valid", {28'd0, bus.out_valid}, 32'h0);
        check("drain y2 held", {24'd0, bus.y2}, 32'hA5);
        tick();

        // back-to-back stream into channel 0
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                bus.in_valid = 1'b1;
                bus.in_sel   = 2'd0;
                bus.in_data  = 8'(i + 1);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (i > 0) begin
                check("stream y0", {24'd0, bus.y0}, 32'(i));
                check("stream v0", {31'd0, bus.out_valid[0]}, 32'h1);
            end
            if (i < 4) begin
                check("stream ready", {31'd0, bus.in_ready}, 32'h1);
            end
            tick();
        end
        @(negedge clk);
        check("stream end valid", {28'd0, bus.out_valid}, 32'h0);
        check("stream y0 held", {24'd0, bus.y0}, 32'h4);
        tick();

        // fill all slots then reset mid-operation
        bus.out_ready = 4'b0000;
        for (int s = 0; s < 4; s++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = 2'(s);
            bus.in_data  = 8'(8'h40 + s);
            tick();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("fill valid", {28'd0, bus.out_valid}, 32'hf);
        check("fill y1", {24'd0, bus.y1}, 32'h41);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid rst valid", {28'd0, bus.out_valid}, 32'h0);
        check("mid rst y",
              {bus.y0, bus.y1, bus.y2, bus.y3}, 32'h0);
        check("mid rst ready", {31'd0, bus.in_ready}, 32'h1);
        tick();

        // 257 transfers on channel 0
        bus.out_ready = 4'b1111;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        for (int i = 0; i < 257; i++) begin
            bus.in_data = 8'(i * 7 + 3);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("long valid", {28'd0, bus.out_valid}, 32'h0);
`ifdef BUS_DEMUX_COUNT_EN
        check("cnt0", {24'd0, cnt0}, 32'h1);
        check("cnt1", {24'd0, cnt1}, 32'h0);
        check("cnt2", {24'd0, cnt2}, 32'h0);
        check("cnt3", {24'd0, cnt3}, 32'h0);
`endif
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bus_demux_1to4_reg.md
BUS_DEMUX_1TO4_REG -- requirements
Module: bus_demux_1to4_reg

Interface
REQ-001 Parameter BUS_WIDTH, default 8, SHALL set the data width of the input bus and of every output bus.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RST  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-004 IN_DATA  input  BUS_WIDTH  SHALL carry the upstream data word.
REQ-005 IN_SEL  input  2  SHALL give the destination channel index (0..3).
REQ-006 IN_VALID  input  1  SHALL flag that IN_DATA/IN_SEL are valid.
REQ-007 IN_READY  output  1  SHALL flag that the module accepts the word this cycle.
REQ-008 Y0, Y1, Y2, Y3  output  BUS_WIDTH each  SHALL be the registered data of channels 0-3.
REQ-009 OUT_VALID  output  4  SHALL flag, per channel, that Yn holds an undelivered word.
REQ-010 OUT_READY  input  4  SHALL flag, per channel, that downstream takes Yn this cycle.

Function
REQ-011 Upstream transfer SHALL occur when IN_VALID and IN_READY are both high at a rising CLK edge.
REQ-012 Channel n transfer SHALL occur when OUT_VALID[n] and OUT_READY[n] are both high at a rising CLK edge.
REQ-013 IN_READY SHALL equal ~OUT_VALID[IN_SEL] | OUT_READY[IN_SEL]; this is a combinational path, and IN_READY SHALL not depend on IN_VALID.
REQ-014 On an upstream transfer, IN_DATA SHALL be written into slot IN_SEL, and OUT_VALID[IN_SEL] SHALL be high on the next cycle (latency 1 cycle).
REQ-015 A full slot SHALL draining and being refilled in the same cycle: OUT_VALID stays high and Yn takes the new word (sustained 1 word/cycle per channel).
REQ-016 A channel transfer with no refill SHALL clear OUT_VALID[n] on the next cycle; Yn SHALL hold its last value.
REQ-017 Slots not addressed by IN_SEL SHALL be unaffected by upstream activity, and each SHALL drain independently.
REQ-018 Yn SHALL remain stable while OUT_VALID[n] is high and OUT_READY[n] is low.
REQ-019 While IN_VALID is low, IN_SEL and IN_DATA SHALL be ignored.
REQ-020 Per-slot state machine: EMPTY->FULL on write; FULL->EMPTY on drain without write; FULL->FULL on drain with write, or on no drain.

Reset
REQ-021 While RST is high, OUT_VALID SHALL be 4'b0000 and Y0..Y3 SHALL be all-zero from the next edge onward.
REQ-022 RST asserted mid-operation SHALL discard every held word, and no transfer SHALL be reported on that edge.
REQ-023 IN_READY SHALL follow REQ-013 after reset, and SHALL therefore be high after reset.

Configuration
REQ-024 With macro BUS_DEMUX_COUNT_EN defined, the module SHALL add output CNT0..CNT3 (8 bits each), counting channel transfers.
REQ-025 Each counter SHALL be reset to 0 and SHALL wrap from 255 to 0.
REQ-026 Without BUS_DEMUX_COUNT_EN, the counter ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 A shared package bus_demux_pkg SHALL hold NUM_OUT=4, SEL_W=2, CNT_W=8 and the slot-state typedef (EMPTY, FULL).
REQ-028 One sub-module, bus_demux_slot, SHALL implement a single one-entry register slot and SHALL be instantiated four times.

Verification
REQ-029 Reset with OUT_READY=4'b0000, then send IN_DATA=8'hA5, IN_SEL=2 -> OUT_VALID=4'b0100 and Y2=8'hA5 one cycle later; Y2 holds while stalled.
REQ-030 Hold channel 1 full with OUT_READY[1]=0 and offer IN_SEL=1 -> IN_READY=0; offer IN_SEL=3 in the same state -> IN_READY=1 and Y3 loads.
REQ-031 Hold OUT_READY=4'b1111 and stream 8'h01..8'h04 to channel 0 back-to-back -> IN_READY stays 1, and Y0 shows 01,02,03,04 on consecutive cycles with OUT_VALID[0] continuously high.
REQ-032 Fill all four slots, then pulse RST for 1 cycle -> OUT_VALID=4'b0000, Y0..Y3=0, and IN_READY=1 after the reset edge.
REQ-033 With BUS_DEMUX_COUNT_EN defined, make 257 transfers on channel 0 -> CNT0=1 and CNT1..CNT3=0.
